// File: rtl/ruta_ctrl_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ruta_ctrl_pipe : MIPS-subset pipelined control with load-use stalling     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module ruta_ctrl_pipe #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  output logic              MEM_RD_I,
  output logic [1:0]        SEL_DIR,
  output logic              resetIF,
  output logic              REG_RD,
  output logic              SEL_IM,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              stall,
  output logic [4:0]        ctrl_EXE,
  output logic [2:0]        ctrl_MEM,
  output logic [1:0]        ctrl_WB,
  output logic [REG_AW-1:0] wr_addr_wb
);

  localparam logic [4:0] C_EXE_BUB    = 5'b00000;
  localparam logic [2:0] C_MEM_BUB    = 3'b111;
  localparam logic [1:0] C_WB_BUB     = 2'b11;
  localparam logic [2:0] C_STALL_INIT = 3'(LOAD_STALL - 1);

  localparam logic [2:0] C_ALU_ADD = 3'd1;
  localparam logic [2:0] C_ALU_SUB = 3'd2;
  localparam logic [2:0] C_ALU_AND = 3'd3;
  localparam logic [2:0] C_ALU_OR  = 3'd4;
  localparam logic [2:0] C_ALU_NOR = 3'd5;
  localparam logic [2:0] C_ALU_CMP = 3'd6;

  logic [2:0]        w_alu;
  logic              w_sel_alu;
  logic              w_sel_reg;
  logic              w_sel_im;
  logic              w_mem_rd;
  logic              w_mem_wr;
  logic              w_wh;
  logic              w_dir_wb;
  logic              w_reg_wr;
  logic              w_reg_rd;
  logic              w_is_j;
  logic              w_is_jr;
  logic              w_uses_rt;
  logic [REG_AW-1:0] w_dest;
  logic              w_ldu_hit;
  logic              w_stall;

  logic [4:0]        r_idex_exe;
  logic [2:0]        r_idex_mem;
  logic [1:0]        r_idex_wb;
  logic [REG_AW-1:0] r_idex_dest;
  logic [2:0]        r_exmem_mem;
  logic [1:0]        r_exmem_wb;
  logic [REG_AW-1:0] r_exmem_dest;
  logic [1:0]        r_memwb_wb;
  logic [REG_AW-1:0] r_memwb_dest;
  logic [2:0]        r_cnt;

  // Defaults are the bubble bundle, so unknown codes fall through harmlessly.
  always_comb begin
    w_alu     = 3'd0;
    w_sel_alu = 1'b0;
    w_sel_reg = 1'b0;
    w_sel_im  = 1'b1;
    w_mem_rd  = 1'b1;
    w_mem_wr  = 1'b1;
    w_wh      = 1'b1;
    w_dir_wb  = 1'b1;
    w_reg_wr  = 1'b1;
    w_reg_rd  = 1'b0;
    w_is_j    = 1'b0;
    w_is_jr   = 1'b0;
    w_uses_rt = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20:   w_alu = C_ALU_ADD;
          6'h22:   w_alu = C_ALU_SUB;
          6'h24:   w_alu = C_ALU_AND;
          6'h25:   w_alu = C_ALU_OR;
          6'h27:   w_alu = C_ALU_NOR;
          6'h2a:   w_alu = C_ALU_CMP;
          6'h08:   w_is_jr = 1'b1;
          default: ;
        endcase
        if (w_alu != 3'd0) begin
          w_sel_reg = 1'b1;
          w_reg_wr  = 1'b0;
          w_uses_rt = 1'b1;
        end
      end
      6'h08: begin
        w_alu = C_ALU_ADD; w_sel_alu = 1'b1; w_sel_im = 1'b0; w_reg_wr = 1'b0;
      end
      6'h0c: begin
        w_alu = C_ALU_AND; w_sel_alu = 1'b1; w_reg_wr = 1'b0;
      end
      6'h0d: begin
        w_alu = C_ALU_OR; w_sel_alu = 1'b1; w_reg_wr = 1'b0;
      end
      6'h0a: begin
        w_alu = C_ALU_CMP; w_sel_alu = 1'b1; w_sel_im = 1'b0; w_reg_wr = 1'b0;
      end
      6'h23: begin
        w_alu = C_ALU_ADD; w_sel_alu = 1'b1; w_sel_im = 1'b0;
        w_mem_rd = 1'b0; w_dir_wb = 1'b0; w_reg_wr = 1'b0;
      end
      6'h2b: begin
        w_alu = C_ALU_ADD; w_sel_alu = 1'b1; w_sel_im = 1'b0;
        w_mem_wr = 1'b0; w_uses_rt = 1'b1;
      end
      6'h29: begin
        w_alu = C_ALU_ADD; w_sel_alu = 1'b1; w_sel_im = 1'b0;
        w_mem_wr = 1'b0; w_wh = 1'b0; w_uses_rt = 1'b1;
      end
      6'h02: begin
        w_is_j = 1'b1; w_reg_rd = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_dest = w_reg_wr ? '0 : (w_sel_reg ? rd : rt);

  // A load in ID/EX whose destination feeds the instruction now in ID.
  assign w_ldu_hit = !r_idex_mem[2] && (r_idex_dest != '0) &&
                     (((r_idex_dest == rs) && !w_is_j) ||
                      ((r_idex_dest == rt) && w_uses_rt));
  assign w_stall   = (r_cnt != 3'd0) || w_ldu_hit;

  assign MEM_RD_I   = 1'b0;
  assign SEL_DIR    = w_stall ? 2'b00 : (w_is_j ? 2'b01 : (w_is_jr ? 2'b10 : 2'b00));
  assign resetIF    = !w_stall && (w_is_j || w_is_jr);
  assign REG_RD     = w_reg_rd;
  assign SEL_IM     = w_sel_im;
  assign pc_en      = !w_stall;
  assign ifid_en    = !w_stall;
  assign stall      = w_stall;
  assign ctrl_EXE   = r_idex_exe;
  assign ctrl_MEM   = r_exmem_mem;
  assign ctrl_WB    = r_memwb_wb;
  assign wr_addr_wb = r_memwb_dest;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idex_exe   <= C_EXE_BUB;
      r_idex_mem   <= C_MEM_BUB;
      r_idex_wb    <= C_WB_BUB;
      r_idex_dest  <= '0;
      r_exmem_mem  <= C_MEM_BUB;
      r_exmem_wb   <= C_WB_BUB;
      r_exmem_dest <= '0;
      r_memwb_wb   <= C_WB_BUB;
      r_memwb_dest <= '0;
      r_cnt        <= 3'd0;
    end else begin
      if (w_stall) begin
        r_idex_exe  <= C_EXE_BUB;
        r_idex_mem  <= C_MEM_BUB;
        r_idex_wb   <= C_WB_BUB;
        r_idex_dest <= '0;
      end else begin
        r_idex_exe  <= {w_alu, w_sel_alu, w_sel_reg};
        r_idex_mem  <= {w_mem_rd, w_mem_wr, w_wh};
        r_idex_wb   <= {w_dir_wb, w_reg_wr};
        r_idex_dest <= w_dest;
      end
      r_exmem_mem  <= r_idex_mem;
      r_exmem_wb   <= r_idex_wb;
      r_exmem_dest <= r_idex_dest;
      r_memwb_wb   <= r_exmem_wb;
      r_memwb_dest <= r_exmem_dest;
      if (r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end else if (w_ldu_hit) begin
        r_cnt <= C_STALL_INIT;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ruta_ctrl_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ruta_ctrl_pipe : bench for ruta_ctrl_pipe against an issue-history model|
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_ruta_ctrl_pipe;
  localparam int AW = 5;
  localparam int LS = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode, funct;
  logic [AW-1:0] rs, rt, rd;
  logic          MEM_RD_I, resetIF, REG_RD, SEL_IM, pc_en, ifid_en, stall;
  logic [1:0]    SEL_DIR, ctrl_WB;
  logic [4:0]    ctrl_EXE;
  logic [2:0]    ctrl_MEM;
  logic [AW-1:0] wr_addr_wb;

  always #5 clk = ~clk;

  ruta_ctrl_pipe #(.REG_AW(AW), .LOAD_STALL(LS)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .MEM_RD_I(MEM_RD_I), .SEL_DIR(SEL_DIR),
    .resetIF(resetIF), .REG_RD(REG_RD), .SEL_IM(SEL_IM), .pc_en(pc_en),
    .ifid_en(ifid_en), .stall(stall), .ctrl_EXE(ctrl_EXE), .ctrl_MEM(ctrl_MEM),
    .ctrl_WB(ctrl_WB), .wr_addr_wb(wr_addr_wb)
  );

  typedef enum logic [3:0] {M_ADD, M_AND, M_NOR, M_OR, M_SLT, M_SUB, M_JR,
                            M_ADDI, M_ANDI, M_ORI, M_SLTI, M_LW, M_SW, M_SH, M_J} mn_t;
  typedef struct packed { mn_t mn; logic [AW-1:0] rs, rt, rd; } ins_t;
  typedef struct packed { logic [4:0] exe; logic [2:0] mem; logic [1:0] wb;
                          logic [AW-1:0] dest; logic is_lw; } bun_t;

  int   checks = 0, errors = 0;
  int   n_st, n_rif, n_jr;
  int   m_left;
  bun_t hist [3];

  function automatic bun_t bub();
    bun_t b;
    b.exe = 5'b00000; b.mem = 3'b111; b.wb = 2'b11; b.dest = '0; b.is_lw = 1'b0;
    return b;
  endfunction

  function automatic logic [11:0] enc(mn_t m);
    case (m)
      M_ADD:   return {6'h00, 6'h20};
      M_AND:   return {6'h00, 6'h24};
      M_NOR:   return {6'h00, 6'h27};
      M_OR:    return {6'h00, 6'h25};
      M_SLT:   return {6'h00, 6'h2a};
      M_SUB:   return {6'h00, 6'h22};
      M_JR:    return {6'h00, 6'h08};
      M_ADDI:  return {6'h08, 6'h00};
      M_ANDI:  return {6'h0c, 6'h00};
      M_ORI:   return {6'h0d, 6'h00};
      M_SLTI:  return {6'h0a, 6'h00};
      M_LW:    return {6'h23, 6'h00};
      M_SW:    return {6'h2b, 6'h00};
      M_SH:    return {6'h29, 6'h00};
      default: return {6'h02, 6'h00};
    endcase
  endfunction

  function automatic bit is_ralu(mn_t m);
    return m inside {M_ADD, M_AND, M_NOR, M_OR, M_SLT, M_SUB};
  endfunction

  function automatic bun_t dec(ins_t i);
    bun_t b; logic [2:0] alu; logic wr;
    case (i.mn)
      M_ADD, M_ADDI, M_LW, M_SW, M_SH: alu = 3'd1;
      M_SUB:                           alu = 3'd2;
      M_AND, M_ANDI:                   alu = 3'd3;
      M_OR, M_ORI:                     alu = 3'd4;
      M_NOR:                           alu = 3'd5;
      M_SLT, M_SLTI:                   alu = 3'd6;
      default:                         alu = 3'd0;
    endcase
    wr      = i.mn inside {M_J, M_JR, M_SW, M_SH};
    b.exe   = {alu, 1'(i.mn inside {M_ADDI, M_ANDI, M_ORI, M_SLTI, M_LW, M_SW, M_SH}),
               1'(is_ralu(i.mn))};
    b.mem   = {i.mn != M_LW, 1'(!(i.mn inside {M_SW, M_SH})), i.mn != M_SH};
    b.wb    = {i.mn != M_LW, wr};
    b.dest  = wr ? '0 : (is_ralu(i.mn) ? i.rd : i.rt);
    b.is_lw = (i.mn == M_LW);
    return b;
  endfunction

  function automatic ins_t mk(mn_t m, int s, int t, int d);
    ins_t i;
    i.mn = m; i.rs = AW'(s); i.rt = AW'(t); i.rd = AW'(d);
    return i;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive ID, check before the edge, then advance the model on the edge.
  task automatic tick(input ins_t i, input bit rst, output bit st);
    bun_t b; bit hz, uses_rt; logic [11:0] e; logic [1:0] dir;
    e       = enc(i.mn);
    reset   = rst;
    opcode  = e[11:6];
    funct   = (e[11:6] == 6'h00) ? e[5:0] : 6'($urandom);
    rs = i.rs; rt = i.rt; rd = i.rd;
    b       = dec(i);
    uses_rt = is_ralu(i.mn) || (i.mn inside {M_SW, M_SH});
    hz = (m_left == 0) && hist[0].is_lw && (hist[0].dest != '0) &&
         (((hist[0].dest == i.rs) && (i.mn != M_J)) || ((hist[0].dest == i.rt) && uses_rt));
    if (hz) m_left = LS;
    st  = (m_left > 0);
    dir = (i.mn == M_J) ? 2'b01 : ((i.mn == M_JR) ? 2'b10 : 2'b00);
    @(negedge clk);
    chk("ctrl_EXE", 8'(ctrl_EXE), 8'(hist[0].exe));
    chk("ctrl_MEM", 8'(ctrl_MEM), 8'(hist[1].mem));
    chk("ctrl_WB", 8'(ctrl_WB), 8'(hist[2].wb));
    chk("wr_addr_wb", 8'(wr_addr_wb), 8'(hist[2].dest));
    chk("stall", 8'(stall), 8'(st));
    chk("pc_en", 8'(pc_en), 8'(!st));
    chk("ifid_en", 8'(ifid_en), 8'(!st));
    chk("SEL_DIR", 8'(SEL_DIR), 8'(st ? 2'b00 : dir));
    chk("resetIF", 8'(resetIF), 8'(!st && (dir != 2'b00)));
    chk("REG_RD", 8'(REG_RD), 8'(i.mn == M_J));
    chk("SEL_IM", 8'(SEL_IM), 8'(!(i.mn inside {M_ADDI, M_SLTI, M_LW, M_SW, M_SH})));
    chk("MEM_RD_I", 8'(MEM_RD_I), 8'd0);
    if (stall === 1'b1) n_st++;
    if (resetIF === 1'b1) n_rif++;
    if (SEL_DIR === 2'b10) n_jr++;
    @(posedge clk);
    if (rst) begin
      hist[0] = bub(); hist[1] = bub(); hist[2] = bub(); m_left = 0;
    end else begin
      hist[2] = hist[1]; hist[1] = hist[0];
      hist[0] = st ? bub() : b;
      if (st) m_left--;
    end
    #1;
  endtask

  // Present one instruction until it issues into ID/EX.
  task automatic run(input ins_t i);
    bit st;
    n_st = 0; n_rif = 0; n_jr = 0;
    do tick(i, 1'b0, st); while (st);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    bit   st;
    ins_t r;
    reset = 1'b1; opcode = 6'h00; funct = 6'h20; rs = '0; rt = '0; rd = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    hist[0] = bub(); hist[1] = bub(); hist[2] = bub(); m_left = 0;
    chk("rst_exe", 8'(ctrl_EXE), 8'h00);
    chk("rst_mem", 8'(ctrl_MEM), 8'h07);
    chk("rst_wb", 8'(ctrl_WB), 8'h03);
    chk("rst_wr", 8'(wr_addr_wb), 8'h00);
    chk("rst_stall", 8'(stall), 8'h00);
    chk("rst_pc_en", 8'(pc_en), 8'h01);

    run(mk(M_ADD, 1, 2, 3));
    chk("add_exe", 8'(ctrl_EXE), 8'b00101);
    run(mk(M_OR, 1, 2, 0));
    chk("add_mem", 8'(ctrl_MEM), 8'b111);
    run(mk(M_OR, 1, 2, 0));
    chk("add_wb", 8'(ctrl_WB), 8'b10);
    chk("add_wr", 8'(wr_addr_wb), 8'd3);

    run(mk(M_LW, 2, 4, 0));
    run(mk(M_OR, 1, 2, 0));
    run(mk(M_OR, 1, 2, 0));
    chk("lw_wb", 8'(ctrl_WB), 8'b00);
    chk("lw_wr", 8'(wr_addr_wb), 8'd4);

    run(mk(M_LW, 1, 4, 0));
    run(mk(M_ADD, 4, 2, 6));
    chk("lu_stalls", 8'(n_st), 8'(LS));

    run(mk(M_LW, 1, 0, 0));
    run(mk(M_ADD, 0, 0, 7));
    chk("r0_stalls", 8'(n_st), 8'd0);

    run(mk(M_LW, 1, 5, 0));
    run(mk(M_JR, 5, 0, 0));
    chk("jr_stalls", 8'(n_st), 8'(LS));
    chk("jr_rif", 8'(n_rif), 8'd1);
    chk("jr_dir", 8'(n_jr), 8'd1);

    run(mk(M_J, 0, 0, 0));
    chk("j_rif", 8'(n_rif), 8'd1);

    run(mk(M_SH, 1, 2, 0));
    run(mk(M_OR, 1, 2, 0));
    chk("sh_mem", 8'(ctrl_MEM), 8'b100);
    run(mk(M_OR, 1, 2, 0));
    chk("sh_wb", 8'(ctrl_WB), 8'b11);

    run(mk(M_LW, 1, 6, 0));
    run(mk(M_LW, 6, 7, 0));
    chk("lwlw_stalls", 8'(n_st), 8'(LS));
    run(mk(M_LW, 1, 3, 0));
    run(mk(M_SW, 1, 3, 0));
    chk("sw_rt_stalls", 8'(n_st), 8'(LS));

    run(mk(M_LW, 1, 5, 0));
    n_st = 0;
    tick(mk(M_ADD, 5, 1, 2), 1'b0, st);
    chk("mid_stall_seen", 8'(n_st), 8'd1);
    tick(mk(M_ADD, 5, 1, 2), 1'b1, st);
    chk("mid_rst_exe", 8'(ctrl_EXE), 8'h00);
    chk("mid_rst_mem", 8'(ctrl_MEM), 8'h07);
    chk("mid_rst_wb", 8'(ctrl_WB), 8'h03);
    chk("mid_rst_wr", 8'(wr_addr_wb), 8'h00);
    run(mk(M_ADD, 5, 1, 2));
    chk("mid_rst_nostall", 8'(n_st), 8'd0);

    for (int k = 0; k < 400; k++) begin
      r.mn = mn_t'(4'($urandom_range(0, 14)));
      r.rs = AW'($urandom_range(0, 7));
      r.rt = AW'($urandom_range(0, 7));
      r.rd = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) tick(r, 1'b1, st);
      else run(r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
